// File: rtl/fft_ram_writer_pkg.sv
// FFT frame geometry and writer state encoding shared by fft_ram_writer and freqdetect.
package fft_ram_writer_pkg;

    localparam int FFT_N_POINTS = 1024;
    localparam int FFT_DW       = 14;
    localparam int FFT_ADDR_W   = $clog2(FFT_N_POINTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fft_ram_writer.sv
// Writes one Avalon-ST FFT output frame into FFT_RAM in arrival order and holds
// fftdone until freqdetect reports the frame consumed.
module fft_ram_writer
    import fft_ram_writer_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int DW       = FFT_DW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sink_valid,
    input  logic                        sink_sop,
    input  logic                        sink_eop,
    input  logic [DW-1:0]               sink_real,
    input  logic [DW-1:0]               sink_imag,
    output logic                        sink_ready,
    output logic                        wren,
    output logic [$clog2(N_POINTS)-1:0] wraddr,
    output logic [2*DW-1:0]             data,
    output logic                        fftdone,
    input  logic                        detectdone,
    output logic                        frame_err
);

    localparam int            AW   = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

    state_t        state;
    logic [AW-1:0] count;
    logic          accept;

    assign accept = sink_valid && sink_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wren       <= 1'b0;
            wraddr     <= '0;
            data       <= '0;
            fftdone    <= 1'b0;
            frame_err  <= 1'b0;
            sink_ready <= 1'b0;
        end else begin
            wren       <= 1'b0;
            frame_err  <= 1'b0;
            sink_ready <= 1'b1;

            // Every accepted beat is written except stray non-SOP beats in IDLE.
            if (accept && (sink_sop || state == WRITE)) begin
                wren   <= 1'b1;
                wraddr <= sink_sop ? '0 : count;
                data   <= {sink_real, sink_imag};
            end

            case (state)
                IDLE: begin
                    fftdone <= 1'b0;
                    if (accept && sink_sop) begin
                        if (sink_eop) begin
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else begin
                            state <= WRITE;
                            count <= AW'(1);
                        end
                    end
                end

                WRITE: begin
                    if (accept) begin
                        if (sink_sop) begin
                            frame_err <= 1'b1;
                            if (sink_eop) begin
                                state <= IDLE;
                                count <= '0;
                            end else begin
                                count <= AW'(1);
                            end
                        end else if (count == LAST) begin
                            if (sink_eop) begin
                                state      <= DONE;
                                sink_ready <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                            count <= '0;
                        end else if (sink_eop) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            count     <= '0;
                        end else begin
                            count <= count + AW'(1);
                        end
                    end
                end

                DONE: begin
                    // fftdone trails DONE entry by a cycle so the last write lands first.
                    if (detectdone) begin
                        state   <= IDLE;
                        fftdone <= 1'b0;
                    end else begin
                        fftdone    <= 1'b1;
                        sink_ready <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    fftdone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ram_writer.sv
// Scoreboard bench for fft_ram_writer: stimulus pushes expected writes, a negedge
// monitor pops and compares them alongside per-cycle control outputs.
module tb_fft_ram_writer;
    import fft_ram_writer_pkg::*;

    localparam int N   = FFT_N_POINTS;
    localparam int DWL = FFT_DW;
    localparam int AW  = FFT_ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, sink_valid, sink_sop, sink_eop, detectdone;
    logic [DWL-1:0]  sink_real, sink_imag;
    logic            sink_ready, wren, fftdone, frame_err;
    logic [AW-1:0]   wraddr;
    logic [2*DWL-1:0] data;

    fft_ram_writer #(.N_POINTS(N), .DW(DWL)) dut (
        .clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_ready(sink_ready), .wren(wren), .wraddr(wraddr), .data(data),
        .fftdone(fftdone), .detectdone(detectdone), .frame_err(frame_err)
    );

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [2*DWL-1:0] d;
    } wr_t;

    int  vectors = 0, miscompares = 0;
    wr_t exp_q[$];
    wr_t got;
    logic [2*DWL-1:0] ram [N];

    // expected-behaviour state: 0 idle, 1 writing, 2 done
    int m_state = 0, m_count = 0;
    bit m_ready = 0, m_done = 0, m_err = 0, m_wr = 0, m_rst = 0;
    bit started = 0;
    int wren_seen = 0, err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int addr, input logic [DWL-1:0] re, input logic [DWL-1:0] im);
        wr_t e;
        e.addr = AW'(addr);
        e.d    = {re, im};
        exp_q.push_back(e);
        m_wr = 1;
    endtask

    task automatic step(input bit rst, input bit v, input bit sop, input bit eop,
                        input logic [DWL-1:0] re, input logic [DWL-1:0] im, input bit dd);
        int prev;
        bit acc;
        reset = rst; sink_valid = v; sink_sop = sop; sink_eop = eop;
        sink_real = re; sink_imag = im; detectdone = dd;
        @(posedge clk);
        #1;
        prev  = m_state;
        m_err = 0;
        m_wr  = 0;
        m_rst = rst;
        if (rst) begin
            m_state = 0; m_count = 0; m_ready = 0; m_done = 0;
        end else begin
            acc = v && m_ready;
            if (prev == 0) begin
                if (acc && sop) begin
                    push(0, re, im);
                    if (eop) m_err = 1;
                    else begin m_state = 1; m_count = 1; end
                end
            end else if (prev == 1 && acc) begin
                if (sop) begin
                    push(0, re, im);
                    m_err = 1;
                    if (eop) m_state = 0; else m_count = 1;
                end else begin
                    push(m_count, re, im);
                    if (m_count == N - 1) begin
                        if (eop) m_state = 2; else begin m_err = 1; m_state = 0; end
                    end else if (eop) begin
                        m_err = 1; m_state = 0;
                    end else begin
                        m_count++;
                    end
                end
            end
            m_done = (prev == 2) && !dd;
            if (prev == 2 && dd) m_state = 0;
            m_ready = (m_state != 2);
        end
        started = 1;
    endtask

    task automatic idle(input int n, input bit dd);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, '0, dd);
    endtask

    task automatic frame(input int n, input int eop_at, input logic [DWL-1:0] key, input bit stall);
        int i, c;
        logic [DWL-1:0] re;
        i = 0; c = 0;
        while (i < n) begin
            if (stall && (c % 3 == 2)) begin
                step(0, 0, 0, 0, 14'h1555, 14'h0AAA, 0);
            end else begin
                re = DWL'(i) ^ key;
                step(0, 1, i == 0, i == eop_at, re, ~re, 0);
                i++;
            end
            c++;
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < N; i++) ram[i] = '1;
    endtask

    task automatic check_ram(input string name, input logic [DWL-1:0] key);
        logic [DWL-1:0] re;
        for (int i = 0; i < N; i++) begin
            re = DWL'(i) ^ key;
            check(name, ram[i], {re, ~re});
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("sink_ready", sink_ready, m_ready);
            check("fftdone", fftdone, m_done);
            check("frame_err", frame_err, m_err);
            check("wren", wren, m_wr);
            if (frame_err === 1'b1) err_seen++;
            if (m_rst) begin
                check("reset_wraddr", wraddr, 0);
                check("reset_data", data, 0);
            end
            if (wren === 1'b1) begin
                wren_seen++;
                ram[wraddr] = data;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wraddr, data);
                end else begin
                    got = exp_q.pop_front();
                    check("wraddr", wraddr, got.addr);
                    check("wdata", data, got.d);
                end
            end
        end
    end

    initial begin
        int w0, e0;
        logic [DWL-1:0] k2;

        // reset state, then ready one cycle after release; stray non-SOP beats dropped
        step(1, 0, 0, 0, '0, '0, 0);
        step(1, 1, 1, 0, 14'h3FFF, 14'h3FFF, 1);
        step(1, 0, 0, 0, '0, '0, 0);
        check("reset_ready", sink_ready, 0);
        step(0, 0, 0, 0, '0, '0, 0);
        check("ready_after_reset", sink_ready, 1);
        w0 = wren_seen;
        for (int k = 0; k < 3; k++) step(0, 1, 0, k == 2, 14'h0123, 14'h0456, 0);
        idle(1, 0);
        check("stray_beats_dropped", wren_seen - w0, 0);

        // full frame, fftdone two cycles after eop
        clear_ram();
        w0 = wren_seen; e0 = err_seen;
        frame(N, N - 1, '0, 0);
        check("fftdone_eop_plus1", fftdone, 0);
        check("ready_in_done", sink_ready, 0);
        idle(1, 0);
        check("fftdone_eop_plus2", fftdone, 1);
        check("full_frame_wren_count", wren_seen - w0, N);
        check("full_frame_no_err", err_seen - e0, 0);
        check_ram("ram_full_frame", '0);

        // beats while DONE are refused, then detectdone releases
        w0 = wren_seen;
        for (int k = 0; k < 5; k++) step(0, 1, k == 0, k == 4, DWL'(k), DWL'(k), 0);
        check("done_refuses_ready", sink_ready, 0);
        step(0, 0, 0, 0, '0, '0, 1);
        check("fftdone_clears", fftdone, 0);
        check("ready_after_detect", sink_ready, 1);
        idle(1, 0);
        check("no_writes_in_done", wren_seen - w0, 0);

        // stalled frame gives identical RAM
        clear_ram();
        w0 = wren_seen;
        frame(N, N - 1, '0, 1);
        idle(2, 0);
        check("stall_fftdone", fftdone, 1);
        check("stall_wren_count", wren_seen - w0, N);
        check_ram("ram_stalled", '0);
        idle(1, 1);

        // detectdone outside DONE ignored; early eop at beat 500
        idle(2, 1);
        e0 = err_seen;
        frame(501, 500, 14'h0111, 0);
        idle(3, 0);
        check("early_eop_err", err_seen - e0, 1);
        check("early_eop_no_done", fftdone, 0);
        frame(N, N - 1, 14'h0222, 0);
        idle(1, 0);
        check("after_early_eop_done", fftdone, 1);
        check("after_early_eop_err", err_seen - e0, 1);
        idle(1, 1);

        // sop re-asserted at beat 300 starts a new full frame
        e0 = err_seen;
        frame(300, -1, '0, 0);
        frame(N, N - 1, 14'h2AA, 0);
        idle(1, 0);
        check("resop_err", err_seen - e0, 1);
        check("resop_done", fftdone, 1);
        k2 = 14'h2AA;
        check("resop_ram0", ram[0], {k2, ~k2});
        idle(1, 1);

        // single beat with sop and eop
        e0 = err_seen;
        step(0, 1, 1, 1, 14'h0ABC, 14'h0DEF, 0);
        idle(2, 0);
        check("sop_eop_err", err_seen - e0, 1);
        check("sop_eop_no_done", fftdone, 0);

        // last index without eop: error, no wrap, no done
        e0 = err_seen;
        frame(N, -1, 14'h0055, 0);
        idle(3, 0);
        check("no_eop_err", err_seen - e0, 1);
        check("no_eop_no_done", fftdone, 0);

        // reset at beat 700 aborts the frame
        frame(700, -1, '0, 0);
        step(1, 1, 0, 0, 14'h1111, 14'h2222, 0);
        check("midframe_reset_wren", wren, 0);
        check("midframe_reset_ready", sink_ready, 0);
        idle(3, 0);
        check("midframe_reset_no_done", fftdone, 0);
        frame(N, N - 1, 14'h0F0F, 0);
        idle(1, 0);
        check("post_reset_frame_done", fftdone, 1);

        // reset while DONE drops fftdone
        step(1, 0, 0, 0, '0, '0, 0);
        check("reset_in_done", fftdone, 0);
        idle(3, 0);
        check("reset_in_done_stays_low", fftdone, 0);

        check("expected_writes_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
